// File: rtl/sal_axi_pkg.sv
// Shared AXI definitions: burst-type encoding, response codes and a
// WRAP-length legality helper used by AXI slave blocks.
package sal_axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } axi_burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    // A WRAP burst must be 2, 4, 8 or 16 beats long.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/sal_axi_ar_fifo.sv
// Two-entry first-word-fall-through buffer for read-address requests.
// The head entry is visible on o_rdata whenever o_empty is low.
module sal_axi_ar_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
    assign o_rdata = r_mem[r_rptr];

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage arrays are not reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/sal_axi_rd_resp.sv
// AXI read-response slave backed by a preloadable word memory.
// Optional macro SAL_AXI_RD_WRAP_EN enables WRAP bursts (otherwise they answer SLVERR).
module sal_axi_rd_resp
    import sal_axi_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_W-1:0]              arid,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic [7:0]                   arlen,
    input  logic [2:0]                   arsize,
    input  logic [1:0]                   arburst,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [ID_W-1:0]              rid,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rlast,
    output logic                         rvalid,
    input  logic                         rready,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
    input  logic [DATA_W-1:0]            mem_wdata
);

    localparam int SHIFT = $clog2(DATA_W / 8);
    localparam int MA_W  = $clog2(MEM_DEPTH);
    localparam int REQ_W = ID_W + ADDR_W + 8 + 3 + 2;

    typedef enum logic {ST_IDLE, ST_BURST} state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic                w_fifo_pop;
    logic                w_load;
    logic                w_full;
    logic                w_empty;
    logic [REQ_W-1:0]    w_req_head;
    logic                w_rlast_hs;

    logic [ID_W-1:0]     w_h_id;
    logic [ADDR_W-1:0]   w_h_addr;
    logic [7:0]          w_h_len;
    logic [2:0]          w_h_size;
    logic [1:0]          w_h_burst;
    logic [ADDR_W-1:0]   w_h_idx;
    logic                w_h_err;

    // Active burst: id, index of the next beat to issue, beats still to issue.
    logic [ID_W-1:0]     r_bid;
    logic [ADDR_W-1:0]   r_bidx;
    logic [8:0]          r_brem;
    axi_burst_e          r_bburst;
    logic                r_berr;

    logic [ID_W-1:0]     w_s_id;
    logic [ADDR_W-1:0]   w_s_idx;
    logic [ADDR_W-1:0]   w_s_idx_nxt;
    logic [8:0]          w_s_rem;
    axi_burst_e          w_s_burst;
    logic                w_s_err;
    logic                w_beat_err;
    logic [DATA_W-1:0]   w_mem_word;

    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];
    logic [ID_W-1:0]     r_rid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;
    logic                r_rlast;
    logic                r_rvalid;

`ifdef SAL_AXI_RD_WRAP_EN
    logic [7:0]          r_bmask;
    logic [7:0]          w_s_mask;
    logic [ADDR_W-1:0]   w_s_mask_ext;
`endif

    assign arready = !w_full && !rst;

    sal_axi_ar_fifo #(.WIDTH(REQ_W)) u_ar_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (arvalid && arready),
        .i_wdata ({arid, araddr, arlen, arsize, arburst}),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_req_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_h_id, w_h_addr, w_h_len, w_h_size, w_h_burst} = w_req_head;
    assign w_h_idx = w_h_addr >> SHIFT;

    // Request-level errors poison every beat of the burst.
    always_comb begin
        w_h_err = (w_h_size != 3'(SHIFT));
        case (axi_burst_e'(w_h_burst))
            FIXED, INCR: w_h_err = w_h_err;
`ifdef SAL_AXI_RD_WRAP_EN
            WRAP:        w_h_err = w_h_err || !wrap_len_ok(w_h_len);
`endif
            default:     w_h_err = 1'b1;
        endcase
    end

    assign w_rlast_hs = r_rvalid && rready && r_rlast;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_fifo_pop  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_rlast_hs) begin
                    if (!w_empty) begin
                        w_fifo_pop = 1'b1;
                        w_load     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if ((r_brem != 9'd0) && (!r_rvalid || rready)) begin
                    w_load = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A pop in BURST issues the new burst's first beat straight from the FIFO head.
    assign w_s_id    = w_fifo_pop ? w_h_id : r_bid;
    assign w_s_idx   = w_fifo_pop ? w_h_idx : r_bidx;
    assign w_s_rem   = w_fifo_pop ? ({1'b0, w_h_len} + 9'd1) : r_brem;
    assign w_s_burst = w_fifo_pop ? axi_burst_e'(w_h_burst) : r_bburst;
    assign w_s_err   = w_fifo_pop ? w_h_err : r_berr;

`ifdef SAL_AXI_RD_WRAP_EN
    assign w_s_mask     = w_fifo_pop ? w_h_len : r_bmask;
    assign w_s_mask_ext = ADDR_W'(w_s_mask);
`endif

    always_comb begin
        w_s_idx_nxt = w_s_idx;
        case (w_s_burst)
            INCR:    w_s_idx_nxt = w_s_idx + ADDR_W'(1);
`ifdef SAL_AXI_RD_WRAP_EN
            WRAP:    w_s_idx_nxt = (w_s_idx & ~w_s_mask_ext) |
                                   ((w_s_idx + ADDR_W'(1)) & w_s_mask_ext);
`endif
            default: w_s_idx_nxt = w_s_idx;
        endcase
    end

    assign w_beat_err = w_s_err || (w_s_idx >= ADDR_W'(MEM_DEPTH));
    assign w_mem_word = r_mem[w_s_idx[MA_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bid    <= '0;
            r_bidx   <= '0;
            r_brem   <= 9'd0;
            r_bburst <= FIXED;
            r_berr   <= 1'b0;
`ifdef SAL_AXI_RD_WRAP_EN
            r_bmask  <= 8'd0;
`endif
        end else if (w_fifo_pop || w_load) begin
            r_bid    <= w_s_id;
            r_bburst <= w_s_burst;
            r_berr   <= w_s_err;
            r_bidx   <= w_load ? w_s_idx_nxt : w_s_idx;
            r_brem   <= w_load ? (w_s_rem - 9'd1) : w_s_rem;
`ifdef SAL_AXI_RD_WRAP_EN
            r_bmask  <= w_s_mask;
`endif
        end
    end

    // Output beat register: loads only when empty or being consumed, so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else if (w_load) begin
            r_rvalid <= 1'b1;
            r_rlast  <= (w_s_rem == 9'd1);
            r_rid    <= w_s_id;
            r_rdata  <= w_beat_err ? '0 : w_mem_word;
            r_rresp  <= w_beat_err ? SLVERR : OKAY;
        end else if (rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) r_mem[mem_waddr] <= mem_wdata;
    end

    assign rid    = r_rid;
    assign rdata  = r_rdata;
    assign rresp  = r_rresp;
    assign rlast  = r_rlast;
    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_sal_axi_rd_resp.sv
// Scoreboard bench for sal_axi_rd_resp: expected beats are queued when an AR
// is accepted and compared as R beats are handshaken.
module tb_sal_axi_rd_resp;
    import sal_axi_pkg::*;

    localparam int ID_W      = 4;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 64;
    localparam int MEM_DEPTH = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ID_W-1:0]   arid = '0;
    logic [ADDR_W-1:0] araddr = '0;
    logic [7:0]        arlen = '0;
    logic [2:0]        arsize = '0;
    logic [1:0]        arburst = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready = 1'b0;
    logic              mem_we = 1'b0;
    logic [7:0]        mem_waddr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;

    always #5 clk = ~clk;

    sal_axi_rd_resp #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] tb_mem [MEM_DEPTH];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                beats_seen = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: word index sequence and per-beat response.
    function automatic void push_burst(input logic [3:0] id, input logic [31:0] addr,
                                       input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        int    idx, base, n;
        bit    err_all;
        beat_t b;
        n       = int'(len) + 1;
        idx     = int'(addr >> 3);
        err_all = (size != 3'd3) || (burst == 2'b11);
        if (burst == 2'b10) begin
`ifdef SAL_AXI_RD_WRAP_EN
            err_all = err_all || !(n == 2 || n == 4 || n == 8 || n == 16);
`else
            err_all = 1'b1;
`endif
        end
        base = (idx / n) * n;
        for (int k = 0; k < n; k++) begin
            b.id   = id;
            b.last = (k == n - 1);
            if (err_all || idx >= MEM_DEPTH) begin
                b.data = '0;
                b.resp = 2'b10;
            end else begin
                b.data = tb_mem[idx];
                b.resp = 2'b00;
            end
            exp_q.push_back(b);
            if (burst == 2'b01)      idx = idx + 1;
            else if (burst == 2'b10) idx = base + ((idx - base + 1) % n);
        end
    endfunction

    always @(negedge clk) begin
        beat_t e;
        if (!rst && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_qsize", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("rid", rid, e.id);
                check("rdata", rdata, e.data);
                check("rresp", rresp, e.resp);
                check("rlast", rlast, e.last);
                beats_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [DATA_W-1:0] d);
        mem_we    = 1'b1;
        mem_waddr = idx[7:0];
        mem_wdata = d;
        tick();
        mem_we    = 1'b0;
        tb_mem[idx] = d;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int waited);
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (!arready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!arready) check("ar_accept_timeout", arready, 1);
        @(posedge clk);
        push_burst(id, addr, len, size, burst);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 500) begin
            tick();
            cyc++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int w3;
        int start;

        repeat (3) @(posedge clk);
        #1;
        check("arready_in_rst", arready, 0);
        check("rvalid_in_rst", rvalid, 0);
        check("rlast_in_rst", rlast, 0);
        check("rid_in_rst", rid, 0);
        check("rdata_in_rst", rdata, 0);
        check("rresp_in_rst", rresp, 0);
        rst = 1'b0;
        @(negedge clk);
        check("arready_after_rst", arready, 1);
        tick();

        for (int i = 0; i < 24; i++) preload(i, DATA_W'(32'h100 + i));
        preload(MEM_DEPTH - 1, 64'hABCD_0000_1234_5678);

        // Basic INCR burst and first-beat latency.
        rready = 1'b1;
        send_ar(4'd3, 32'h0, 8'd3, 3'd3, INCR, w);
        @(negedge clk); check("lat_before_e1", rvalid, 0);
        @(negedge clk); check("lat_after_e1", rvalid, 0);
        @(negedge clk); check("lat_after_e2", rvalid, 1);
        drain("drain_basic");

        // FIFO fills behind a stalled burst; queued bursts then stream without bubbles.
        rready = 1'b0;
        send_ar(4'd5, 32'h40, 8'd3, 3'd3, INCR, w);
        send_ar(4'd1, 32'h0, 8'd1, 3'd3, INCR, w);
        send_ar(4'd2, 32'h20, 8'd0, 3'd3, INCR, w);
        fork
            send_ar(4'd6, 32'h48, 8'd0, 3'd3, INCR, w3);
            begin
                repeat (4) tick();
                rready = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    check("no_bubble", rvalid, 1);
                end
            end
        join
        check("ar3_held", (w3 > 0), 1);
        drain("drain_b2b");

        // Backpressure mid-burst: beat must hold steady.
        start = beats_seen;
        send_ar(4'd7, 32'h10, 8'd3, 3'd3, INCR, w);
        repeat (4) tick();
        rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_rvalid", rvalid, 1);
            if (exp_q.size() != 0) begin
                check("stall_rdata", rdata, exp_q[0].data);
                check("stall_rlast", rlast, exp_q[0].last);
                check("stall_rid", rid, exp_q[0].id);
            end
        end
        tick();
        rready = 1'b1;
        drain("drain_stall");
        check("stall_beat_count", beats_seen - start, 4);

        // Out-of-range index on the second beat only.
        send_ar(4'd4, 32'((MEM_DEPTH - 1) * 8), 8'd1, 3'd3, INCR, w);
        drain("drain_oob");

        // FIXED, bad size, reserved burst, WRAP legal and illegal, under random backpressure.
        fork
            begin
                send_ar(4'd8, 32'h10, 8'd2, 3'd3, FIXED, w);
                send_ar(4'd9, 32'h8, 8'd1, 3'd2, INCR, w);
                send_ar(4'd10, 32'h0, 8'd1, 3'd3, RSVD, w);
                send_ar(4'd11, 32'h30, 8'd3, 3'd3, WRAP, w);
                send_ar(4'd12, 32'h30, 8'd2, 3'd3, WRAP, w);
                send_ar(4'd13, 32'h1C, 8'd2, 3'd3, INCR, w);
            end
            begin
                repeat (80) begin
                    tick();
                    rready = 1'($urandom_range(0, 1));
                end
            end
        join
        rready = 1'b1;
        drain("drain_mixed");

        // Preload write on the same edge the beat is loaded returns old data.
        send_ar(4'd14, 32'(20 * 8), 8'd1, 3'd3, INCR, w);
        tick();
        mem_we    = 1'b1;
        mem_waddr = 8'd20;
        mem_wdata = 64'hDEAD_BEEF_0000_0020;
        tick();
        mem_we    = 1'b0;
        tb_mem[20] = 64'hDEAD_BEEF_0000_0020;
        drain("drain_wr_old");
        send_ar(4'd15, 32'(20 * 8), 8'd0, 3'd3, INCR, w);
        drain("drain_wr_new");

        // Reset mid-burst abandons it; memory survives.
        send_ar(4'd10, 32'h0, 8'd7, 3'd3, INCR, w);
        repeat (4) tick();
        rst = 1'b1;
        @(negedge clk);
        check("arready_mid_rst", arready, 0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rvalid_after_mid_rst", rvalid, 0);
        repeat (6) tick();
        check("rvalid_stays_low", rvalid, 0);
        send_ar(4'd11, 32'h38, 8'd1, 3'd3, INCR, w);
        drain("drain_after_rst");

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
